// File: rtl/clock_pkg.sv
//------------------------------------------------------------------------------
// clock_pkg -- shared widths, limits and FSM states for the timekeeping core
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package clock_pkg;

   localparam int SEC_W    = 6;
   localparam int MIN_W    = 6;
   localparam int HR_W     = 5;

   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;
   localparam int HR24_MAX = 23;
   localparam int HR12_MAX = 12;
   localparam int HR12_MIN = 1;

   typedef enum logic [0:0] {
      RUN = 1'b0,
      SET = 1'b1
   } state_e;

endpackage

`default_nettype wire

// File: rtl/wrap_counter.sv
//------------------------------------------------------------------------------
// wrap_counter -- MIN..MAX counter with clear, increment and wrap indication
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wrap_counter #(
   parameter int WIDTH   = 6,
   parameter int MIN     = 0,
   parameter int MAX     = 59,
   parameter int RST_VAL = MIN
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_en,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_value,
   output logic             o_wrap
);

   localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

   logic [WIDTH-1:0] value_q, value_d;
   logic             at_max;

   assign at_max  = (value_q == MAX_V);
   assign o_wrap  = i_inc & at_max;
   assign o_value = value_q;

   always_comb begin
      value_d = value_q;
      if (i_en) begin
         if (i_clr) begin
            value_d = MIN_V;
         end else if (i_inc) begin
            value_d = at_max ? MIN_V : value_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         value_q <= RST_V;
      end else begin
         value_q <= value_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/clock_time_counter.sv
//------------------------------------------------------------------------------
// clock_time_counter -- seconds/minutes/hours timekeeping with button time-set
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clock_time_counter
   import clock_pkg::*;
#(
   parameter int HOUR_24 = 1
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_en,
   input  logic             i_1hz_stb,
   input  logic             i_set_stb,
   input  logic             i_set_hours,
   input  logic             i_set_minutes,
   output logic [SEC_W-1:0] o_seconds,
   output logic [MIN_W-1:0] o_minutes,
   output logic [HR_W-1:0]  o_hours,
   output logic             o_pm,
   output logic             o_tick
);

   localparam logic            IS_24   = (HOUR_24 != 0);
   localparam int              HR_LO   = IS_24 ? 0 : HR12_MIN;
   localparam int              HR_HI   = IS_24 ? HR24_MAX : HR12_MAX;
   localparam int              HR_RST  = IS_24 ? 0 : HR12_MAX;
   localparam logic [HR_W-1:0] PM_HOUR = HR_W'(11);

   state_e           state_q, state_d;
   logic             set_hours_q, set_minutes_q;
   logic             pm_q, pm_d;
   logic             tick_q, tick_d;
   logic [SEC_W-1:0] sec;
   logic [MIN_W-1:0] min_v;
   logic [HR_W-1:0]  hr;
   logic             sec_wrap, min_wrap, hr_wrap;
   logic             any_held, rise_h, rise_m, set_mode;
   logic             run_stb, set_cyc;
   logic             sec_inc, sec_clr, min_inc, hr_inc;

   assign any_held = i_set_hours | i_set_minutes;
   assign rise_h   = i_set_hours & ~set_hours_q;
   assign rise_m   = i_set_minutes & ~set_minutes_q;
   // A held button already counts as setting in the cycle that enters SET.
   assign set_mode = (state_q == SET) | any_held;
   assign run_stb  = i_en & ~set_mode & i_1hz_stb;
   assign set_cyc  = i_en & set_mode;

   assign sec_inc  = run_stb;
   assign sec_clr  = set_cyc;
   assign min_inc  = (run_stb & sec_wrap) |
                     (set_cyc & i_set_minutes & (rise_m | i_set_stb));
   assign hr_inc   = (run_stb & min_wrap) |
                     (set_cyc & i_set_hours & (rise_h | i_set_stb));

   always_comb begin
      state_d = state_q;
      if (i_en) begin
         case (state_q)
            RUN:     if (any_held)  state_d = SET;
            SET:     if (!any_held) state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   always_comb begin
      tick_d = sec_inc | (sec_clr & (sec != '0)) | min_inc | hr_inc;
      // PM flips on 11->12 and, in 24h mode, back on the 23->0 wrap.
      pm_d   = pm_q ^ ((hr_inc & (hr == PM_HOUR)) | (IS_24 & hr_wrap));
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q       <= RUN;
         set_hours_q   <= 1'b0;
         set_minutes_q <= 1'b0;
         pm_q          <= 1'b0;
         tick_q        <= 1'b0;
      end else begin
         set_hours_q   <= i_set_hours;
         set_minutes_q <= i_set_minutes;
         state_q       <= state_d;
         pm_q          <= pm_d;
         tick_q        <= tick_d;
      end
   end

   wrap_counter #(.WIDTH(SEC_W), .MIN(0), .MAX(SEC_MAX), .RST_VAL(0)) u_sec (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_en      (i_en),
      .i_inc     (sec_inc),
      .i_clr     (sec_clr),
      .o_value   (sec),
      .o_wrap    (sec_wrap)
   );

   wrap_counter #(.WIDTH(MIN_W), .MIN(0), .MAX(MIN_MAX), .RST_VAL(0)) u_min (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_en      (i_en),
      .i_inc     (min_inc),
      .i_clr     (1'b0),
      .o_value   (min_v),
      .o_wrap    (min_wrap)
   );

   wrap_counter #(.WIDTH(HR_W), .MIN(HR_LO), .MAX(HR_HI), .RST_VAL(HR_RST)) u_hr (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_en      (i_en),
      .i_inc     (hr_inc),
      .i_clr     (1'b0),
      .o_value   (hr),
      .o_wrap    (hr_wrap)
   );

   assign o_seconds = sec;
   assign o_minutes = min_v;
   assign o_hours   = hr;
   assign o_pm      = pm_q;
   assign o_tick    = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_time_counter.sv
//------------------------------------------------------------------------------
// tb_clock_time_counter -- 24h and 12h instances against a time-of-day model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_clock_time_counter;

   logic       clk, rst_n, en, hz, stb, sh, sm;
   logic [5:0] s24, m24, s12, m12;
   logic [4:0] h24, h12;
   logic       pm24, t24, pm12, t12;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 0;
   int ticks;

   // Model state: time of day held as 24h hh:mm:ss.
   int m_hh, m_mm, m_ss;
   bit m_tick, m_in_set, m_prev_h, m_prev_m;

   clock_time_counter #(.HOUR_24(1)) u_dut24 (
      .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_1hz_stb(hz), .i_set_stb(stb),
      .i_set_hours(sh), .i_set_minutes(sm), .o_seconds(s24), .o_minutes(m24),
      .o_hours(h24), .o_pm(pm24), .o_tick(t24)
   );

   clock_time_counter #(.HOUR_24(0)) u_dut12 (
      .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_1hz_stb(hz), .i_set_stb(stb),
      .i_set_hours(sh), .i_set_minutes(sm), .o_seconds(s12), .o_minutes(m12),
      .o_hours(h12), .o_pm(pm12), .o_tick(t12)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int hour12(input int h);
      return (h % 12 == 0) ? 12 : h % 12;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hh = 0; m_mm = 0; m_ss = 0;
      m_tick = 0; m_in_set = 0; m_prev_h = 0; m_prev_m = 0;
   endtask

   task automatic model_step();
      bit held, rise_h, rise_m, setting;
      int t;
      m_tick = 0;
      if (en) begin
         held    = sh || sm;
         rise_h  = sh && !m_prev_h;
         rise_m  = sm && !m_prev_m;
         setting = m_in_set || held;
         if (setting) begin
            if (m_ss != 0) begin m_ss = 0; m_tick = 1; end
            if (sm && (rise_m || stb)) begin m_mm = (m_mm + 1) % 60; m_tick = 1; end
            if (sh && (rise_h || stb)) begin m_hh = (m_hh + 1) % 24; m_tick = 1; end
            m_in_set = held;
         end else if (hz) begin
            t    = (m_hh * 3600 + m_mm * 60 + m_ss + 1) % 86400;
            m_hh = t / 3600;
            m_mm = (t / 60) % 60;
            m_ss = t % 60;
            m_tick = 1;
         end
      end
      m_prev_h = sh;
      m_prev_m = sm;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (rst_n) model_step();
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("sec24",  s24,  m_ss);
         check("min24",  m24,  m_mm);
         check("hr24",   h24,  m_hh);
         check("pm24",   pm24, int'(m_hh >= 12));
         check("tick24", t24,  m_tick);
         check("sec12",  s12,  m_ss);
         check("min12",  m12,  m_mm);
         check("hr12",   h12,  hour12(m_hh));
         check("pm12",   pm12, int'(m_hh >= 12));
         check("tick12", t12,  m_tick);
      end
   end

   task automatic cyc(input bit e, input bit hz_i, input bit stb_i, input bit sh_i, input bit sm_i);
      @(negedge clk);
      en = e; hz = hz_i; stb = stb_i; sh = sh_i; sm = sm_i;
      @(posedge clk);
      #1;
      hz = 0; stb = 0;
      if (t24) ticks++;
   endtask

   task automatic reset_pulse(input bit lit);
      @(posedge clk);
      #2;
      rst_n = 0; hz = 0; stb = 0;
      model_reset();
      #1;
      if (lit) begin
         check("rst_sec", s24, 0);
         check("rst_min", m24, 0);
         check("rst_hr24", h24, 0);
         check("rst_hr12", h12, 12);
         check("rst_pm", pm12, 0);
         check("rst_tick", t24, 0);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic set_hours_to(input int target);
      int guard = 0;
      cyc(1, 0, 0, 1, 0);
      while (m_hh != target && guard < 30) begin
         cyc(1, 0, 1, 1, 0);
         guard++;
      end
      cyc(1, 0, 0, 0, 0);
   endtask

   task automatic set_minutes_to(input int target);
      int guard = 0;
      cyc(1, 0, 0, 0, 1);
      while (m_mm != target && guard < 70) begin
         cyc(1, 0, 1, 0, 1);
         guard++;
      end
      cyc(1, 0, 0, 0, 0);
   endtask

   task automatic run_secs(input int n);
      repeat (n) cyc(1, 1, 0, 0, 0);
   endtask

   initial begin
      bit r_sh, r_sm;
      int exp_m[3];
      rst_n = 0; en = 0; hz = 0; stb = 0; sh = 0; sm = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n  = 1;
      chk_on = 1;
      #1;
      check("init_sec", s24, 0);
      check("init_hr24", h24, 0);
      check("init_hr12", h12, 12);
      check("init_pm12", pm12, 0);
      check("init_tick", t24, 0);

      // 60 one-second strobes roll one minute
      ticks = 0;
      run_secs(60);
      check("60s_ticks", ticks, 60);
      check("60s_min", m24, 1);
      check("60s_sec", s24, 0);

      // Disabled: strobes and a press are ignored, press does not fire later
      ticks = 0;
      repeat (5) cyc(0, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 1);
      check("dis_ticks", ticks, 0);
      check("dis_min", m24, 1);
      check("dis_sec", s24, 0);
      cyc(1, 0, 0, 0, 1);
      check("reen_min", m24, 1);
      check("reen_tick", t24, 0);
      cyc(1, 0, 1, 0, 1);
      check("reen_stb_min", m24, 2);
      cyc(1, 0, 0, 0, 0);

      // 23:59:59 -> 00:00:00 in one update
      set_hours_to(23);
      set_minutes_to(59);
      run_secs(59);
      check("pre_hr", h24, 23);
      check("pre_min", m24, 59);
      check("pre_sec", s24, 59);
      cyc(1, 1, 0, 0, 0);
      check("midn_hr", h24, 0);
      check("midn_min", m24, 0);
      check("midn_sec", s24, 0);
      check("midn_tick", t24, 1);
      check("midn_hr12", h12, 12);
      check("midn_pm12", pm12, 0);

      // 12h: 11:59:59 -> 12:00:00 PM, then 12:59:59 -> 1:00:00 PM
      set_hours_to(11);
      set_minutes_to(59);
      run_secs(59);
      check("pm_pre_pm", pm12, 0);
      cyc(1, 1, 0, 0, 0);
      check("noon_hr12", h12, 12);
      check("noon_pm12", pm12, 1);
      check("noon_hr24", h24, 12);
      set_minutes_to(59);
      run_secs(59);
      cyc(1, 1, 0, 0, 0);
      check("one_hr12", h12, 1);
      check("one_pm12", pm12, 1);
      check("one_hr24", h24, 13);
      check("one_min", m12, 0);

      // Minutes set wraps without carry; 1 Hz ignored while setting
      set_minutes_to(58);
      run_secs(3);
      check("mset_pre_sec", s24, 3);
      cyc(1, 0, 0, 0, 1);
      check("mset_rise_min", m24, 59);
      check("mset_rise_sec", s24, 0);
      exp_m[0] = 0; exp_m[1] = 1; exp_m[2] = 2;
      for (int k = 0; k < 3; k++) begin
         cyc(1, 1, 1, 0, 1);
         check("mset_min", m24, exp_m[k]);
         check("mset_sec", s24, 0);
         check("mset_hr", h24, 13);
      end

      // Rising edge + 1 Hz + set strobe together: one increment, seconds 0
      cyc(1, 0, 0, 0, 0);
      run_secs(2);
      cyc(1, 1, 1, 0, 1);
      check("coin_min", m24, 3);
      check("coin_sec", s24, 0);
      cyc(1, 0, 0, 0, 0);
      check("exit_tick", t24, 0);
      cyc(1, 1, 0, 0, 0);
      check("exit_sec", s24, 1);

      // Reset in the middle of setting hours
      cyc(1, 0, 0, 1, 0);
      cyc(1, 0, 1, 1, 0);
      sh = 0;
      reset_pulse(1);
      cyc(1, 1, 0, 0, 0);
      check("postrst_sec", s24, 1);
      check("postrst_hr12", h12, 12);

      // Randomized traffic
      r_sh = 0; r_sm = 0;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 799) == 0) reset_pulse(0);
         if (r_sh) r_sh = ($urandom_range(0, 7) != 0);
         else      r_sh = ($urandom_range(0, 39) == 0);
         if (r_sm) r_sm = ($urandom_range(0, 7) != 0);
         else      r_sm = ($urandom_range(0, 39) == 0);
         cyc($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 0,
             $urandom_range(0, 3) == 0, r_sh, r_sm);
      end
      cyc(1, 0, 0, 0, 0);
      @(negedge clk);
      chk_on = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
